// File: rtl/motor_link_pkg.sv
// Shared constants and types for the motor command link receiver.
// Holds the frame header, the speed ceiling and the state encodings.
package motor_link_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;
    localparam logic [7:0] SPEED_MAX = 8'h80;

    typedef logic [7:0] speed_t;

    typedef enum logic [1:0] {
        WAIT_HDR,
        GET_L,
        GET_R,
        GET_CHK
    } parser_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Speeds are unsigned Q1.7, so anything above 1.0 is pinned to 1.0.
    function automatic speed_t clamp_speed(input logic [7:0] raw);
        return (raw > SPEED_MAX) ? SPEED_MAX : raw;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop input synchroniser and mid-bit sampling.
// Emits a one-cycle byte_stb on a good stop bit, or byte_err on a bad one.
module uart_rx_byte
    import motor_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       byte_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        state_q, state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_sync_q, rx_sync_d;
    logic             rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;

    // Synchroniser and edge history reset low so a line held low at reset
    // release is not mistaken for a start bit until it has gone high first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RX_IDLE;
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
            rx_prev_q <= 1'b0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            rx_prev_q <= rx_prev_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST && bit_idx_q == 3'd7) begin
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
        rx_prev_d = rx_sync_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_stb  = 1'b0;
        byte_err  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    byte_stb = rx_sync_q;
                    byte_err = !rx_sync_q;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/motor_cmd_rx.sv
// Motor command link receiver: parses [A5, L, R, CHK] frames into clamped speeds.
// Optional command watchdog enabled by defining CMD_TIMEOUT_EN.
module motor_cmd_rx
    import motor_link_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int TIMEOUT_MS = 100
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] left_speed,
    output logic [7:0] right_speed,
    output logic       cmd_valid,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;

    logic [7:0] rx_byte;
    logic       byte_stb;
    logic       byte_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx_byte (
        .clk     (CLOCK_50),
        .reset   (reset),
        .rx      (rx),
        .rx_byte (rx_byte),
        .byte_stb(byte_stb),
        .byte_err(byte_err)
    );

    parser_state_t state_q, state_d;
    logic [7:0]    l_raw_q, l_raw_d;
    logic [7:0]    r_raw_q, r_raw_d;
    speed_t        left_q, left_d;
    speed_t        right_q, right_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          chk_ok;

`ifdef CMD_TIMEOUT_EN
    localparam logic [31:0] WDOG_LIMIT =
        32'((64'(TIMEOUT_MS) * 64'(CLK_HZ)) / 64'd1000);
    logic [31:0] wdog_q, wdog_d;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= WAIT_HDR;
            l_raw_q     <= '0;
            r_raw_q     <= '0;
            left_q      <= '0;
            right_q     <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            l_raw_q     <= l_raw_d;
            r_raw_q     <= r_raw_d;
            left_q      <= left_d;
            right_q     <= right_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // A stop-bit error abandons whatever frame was in progress.
    always_comb begin
        state_d = state_q;
        if (byte_err) begin
            state_d = WAIT_HDR;
        end else if (byte_stb) begin
            case (state_q)
                WAIT_HDR: state_d = (rx_byte == FRAME_HDR) ? GET_L : WAIT_HDR;
                GET_L:    state_d = GET_R;
                GET_R:    state_d = GET_CHK;
                GET_CHK:  state_d = WAIT_HDR;
                default:  state_d = WAIT_HDR;
            endcase
        end
    end

    // The checksum covers the raw bytes; clamping applies only to the loaded speeds.
    always_comb begin
        l_raw_d     = l_raw_q;
        r_raw_d     = r_raw_q;
        left_d      = left_q;
        right_d     = right_q;
        cmd_valid_d = 1'b0;
        frame_err_d = byte_err;
        chk_ok      = (rx_byte == (FRAME_HDR ^ l_raw_q ^ r_raw_q));
        if (byte_stb) begin
            case (state_q)
                GET_L: l_raw_d = rx_byte;
                GET_R: r_raw_d = rx_byte;
                GET_CHK: begin
                    if (chk_ok) begin
                        left_d      = clamp_speed(l_raw_q);
                        right_d     = clamp_speed(r_raw_q);
                        cmd_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
`ifdef CMD_TIMEOUT_EN
        wdog_d = wdog_q;
        if (cmd_valid_d) begin
            wdog_d = '0;
        end else if (wdog_q != WDOG_LIMIT) begin
            wdog_d = wdog_q + 32'd1;
            if (wdog_q == WDOG_LIMIT - 32'd1) begin
                left_d  = '0;
                right_d = '0;
            end
        end
`else
        // Without the watchdog the last commanded speeds are held indefinitely.
`endif
    end

    assign left_speed  = left_q;
    assign right_speed = right_q;
    assign cmd_valid   = cmd_valid_q;
    assign frame_err   = frame_err_q;

endmodule
